// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    ERRCHK,
    GAP
  } tx_state_t;

  localparam logic [1:0] ILLEGAL_ADDR = 2'b11;
  localparam int         MAX_LEN      = 63;

  function automatic logic [7:0] build_header(input logic [1:0] addr, input logic [5:0] len);
    return {len, addr};
  endfunction

  function automatic logic [7:0] parity_update(input logic [7:0] parity, input logic [7:0] data);
    return parity ^ data;
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: one synchronous write port, one combinational read port.
module router_tx_buf
  import router_pkg::*;
(
  input  logic       clock,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [MAX_LEN+1];

  // Storage is deliberately not reset; contents are only read after being written.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the 1x3 router input: buffers a payload, then sends
// header, payload and parity under busy flow control and reports router error.
//
// state   | meaning
// IDLE    | ready for a request
// LOAD    | collecting payload bytes into the buffer
// HEADER  | header byte on data_out, waiting for !busy
// PAYLOAD | payload bytes on data_out
// PARITY  | parity byte on data_out, pkt_valid low
// ERRCHK  | sampling router error for ERR_WAIT cycles
// GAP     | enforced idle time between packets
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int ERR_WAIT   = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  input  logic       busy,
  input  logic       error,
  output logic       req_err,
  output logic       done,
  output logic       done_err
);

  tx_state_t  state, state_nxt;
  logic [1:0] addr_q;
  logic [5:0] len_q;
  logic [5:0] idx;
  logic [7:0] parity;
  logic [7:0] cnt;
  logic [7:0] gap_cnt;
  logic       err_seen;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;

  logic req_fire, req_bad, pl_fire, take, last_idx, cnt_tc, gap_tc;

  assign req_fire = req_valid & req_ready & (state == IDLE);
  assign req_bad  = (req_addr == ILLEGAL_ADDR) || (req_len == 6'd0);
  assign pl_fire  = pl_valid & pl_ready & (state == LOAD);
  assign take     = ~busy;
  assign last_idx = (idx == len_q - 6'd1);
  assign cnt_tc   = (cnt <= 8'd1);
  assign gap_tc   = (gap_cnt <= 8'd1);

  // Read address looks one byte ahead so data_out can be loaded on acceptance.
  assign rd_addr = (state == PAYLOAD) ? idx + 6'd1 : 6'd0;

  router_tx_buf u_buf (
    .clock   (clock),
    .wr_en   (pl_fire),
    .wr_addr (idx),
    .wr_data (pl_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire && !req_bad) state_nxt = LOAD;
      LOAD:    if (pl_fire && last_idx) state_nxt = HEADER;
      HEADER:  if (take) state_nxt = PAYLOAD;
      PAYLOAD: if (take && last_idx) state_nxt = PARITY;
      PARITY:  if (take) state_nxt = ERRCHK;
      ERRCHK:  if (cnt_tc) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_ready <= 1'b0;
      pl_ready  <= 1'b0;
      pkt_valid <= 1'b0;
      data_out  <= 8'd0;
      req_err   <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      idx       <= 6'd0;
      parity    <= 8'd0;
      cnt       <= 8'd0;
      gap_cnt   <= 8'd0;
      err_seen  <= 1'b0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      pl_ready  <= (state_nxt == LOAD);
      req_err   <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            if (req_bad) begin
              req_err <= 1'b1;
            end else begin
              addr_q <= req_addr;
              len_q  <= req_len;
              parity <= build_header(req_addr, req_len);
              idx    <= 6'd0;
            end
          end
        end
        LOAD: begin
          if (pl_fire) begin
            parity <= parity_update(parity, pl_data);
            if (last_idx) begin
              idx       <= 6'd0;
              pkt_valid <= 1'b1;
              data_out  <= build_header(addr_q, len_q);
            end else begin
              idx <= idx + 6'd1;
            end
          end
        end
        HEADER: begin
          if (take) data_out <= rd_data;
        end
        PAYLOAD: begin
          if (take) begin
            if (last_idx) begin
              pkt_valid <= 1'b0;
              data_out  <= parity;
            end else begin
              idx      <= idx + 6'd1;
              data_out <= rd_data;
            end
          end
        end
        PARITY: begin
          if (take) begin
            cnt      <= 8'(ERR_WAIT);
            err_seen <= 1'b0;
          end
        end
        ERRCHK: begin
          if (cnt_tc) begin
            done      <= 1'b1;
            done_err  <= err_seen | error;
            pkt_valid <= 1'b0;
            data_out  <= 8'd0;
            gap_cnt   <= 8'(GAP_CYCLES);
          end else begin
            cnt      <= cnt - 8'd1;
            err_seen <= err_seen | error;
          end
        end
        GAP: begin
          if (!gap_tc) gap_cnt <= gap_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
